sub_word_store_ctrl: RTL
========================

# sub_word_store_ctrl

Sequencer for data-memory stores in the single-cycle/multi-cycle MIPS core. Accepts one store request at a time (SW, SH, SB), and drives a single-port synchronous data memory. SH and SB run a read-modify-write: read the old word, merge the new halfword or byte into the addressed lane, write the word back. SW writes directly. Sits between the MEM stage store request and the DM word port. Misaligned or reserved requests are reported and never touch memory.

## Interface
- `AW`, default 32: byte-address width.
- `DM_AW`, default 10: memory word-address width. The memory holds 1024 words.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `req_valid` in 1: a store request is presented.
- `req_ready` out 1: the controller accepts a request this cycle.
- `req_type` in 2: 00 = SW, 01 = SH, 10 = SB, 11 = reserved.
- `req_addr` in AW: byte address.
- `req_data` in 32: store data. SH uses [15:0]; SB uses [7:0].
- `done` out 1: one-cycle pulse when the write is issued.
- `err` out 1: one-cycle pulse when a request is rejected.
- `mem_addr` out DM_AW: word address, equal to addr[DM_AW+1:2].
- `mem_re` out 1: read strobe. Data returns on `mem_rdata` in the next cycle.
- `mem_rdata` in 32: read data.
- `mem_we` out 1: write strobe.
- `mem_wdata` out 32: write data.

## Operation
- States: IDLE, READ, MERGE, WRITE, ERR.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, latch type, addr and data.
  - Go to WRITE for SW, READ for SH/SB, ERR for a bad request.
- **Bad request** (goes to ERR):
  - SW with addr[1:0] ≠ 0;
  - SH with addr[0] = 1;
  - type 11.
- **READ**: `mem_re` = 1 and `mem_addr` = latched word address. Next state MERGE.
- **MERGE**
  - Capture the merged word into `wbuf`, then go to WRITE.
  - SB lane n = addr[1:0] replaces bits [8n+7:8n] of `mem_rdata`.
  - SH with addr[1] = 0 gives {rdata[31:16], half}.
  - SH with addr[1] = 1 gives {half, rdata[15:0]}.
- **WRITE**
  - `mem_we` = 1 and `done` = 1.
  - `mem_wdata` = `wbuf` for SH/SB, or the latched data for SW.
  - Next state IDLE.
- **ERR**: `err` = 1, then IDLE. No `mem_re` or `mem_we` is asserted for the request.
- All outputs are registered or decoded from state only. There is no combinational path from `req_*` to `mem_*`.

## Timing
- **Reset values:** state IDLE, `req_ready` = 1, `done` = `err` = `mem_re` = `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- **Reset asserted mid-operation:** return to IDLE immediately (asynchronously). Any in-flight write is dropped. `mem_we` falls with reset and does not wait for a clock edge.
- **Latency from the accept edge (edge 0):**
  - SW: `done`/`mem_we` in cycle 1.
  - SH/SB: `mem_re` in cycle 1, merge in cycle 2, `done`/`mem_we` in cycle 3.
  - Bad request: `err` in cycle 1.
- **Back-to-back:** `req_ready` is 0 outside IDLE, so the next request is accepted at the edge that ends the WRITE or ERR cycle.
  - Throughput: SW 1 per 2 cycles; SH/SB 1 per 4 cycles.
- **Request lifetime:** `req_*` may change freely after acceptance. The latched copy is used.
- **`req_valid` without `req_ready`:** ignored. There is no queuing.

## Structure
- Package `store_pkg`:
  - req_type encodings (`ST_SW`, `ST_SH`, `ST_SB`);
  - state enum;
  - the misalignment check function.
- Sub-module `byte_lane_merge`: combinational. Inputs are old word, new data, type and addr[1:0]; output is the merged word. It implements the SB and SH lane rules above.
- Top module: FSM, request latch, `wbuf`.

## Test plan
- SW at 0x0000_0010 with 0xDEADBEEF → `mem_we` in cycle 1, `mem_addr` = 4, `mem_wdata` = 0xDEADBEEF, `done` pulse, no `mem_re`.
- SB at 0x0000_0022 with 0x5A, old word 0x11223344 → `mem_re` in cycle 1, `mem_we` in cycle 3 with 0x115A3344.
- SH at 0x0000_0002 with 0xABCD, old word 0x11223344 → written word 0xABCD3344. SH at 0x0 → 0x1122ABCD.
- SH at 0x0000_0003, SW at 0x0000_0006, type 11 → each gives an `err` pulse in cycle 1, with `mem_re` and `mem_we` never asserted.
- Two SBs back-to-back with `req_valid` held high → second accepted exactly 4 cycles after the first. Second merge uses fresh `mem_rdata`.
- `reset` pulled low during MERGE of an SB → `mem_we` never rises, state is IDLE and `req_ready` = 1 after release.

Source files
------------

// File: rtl/store_pkg.sv
// Shared encodings and request validity check for the sub-word store sequencer.
package store_pkg;

  localparam logic [1:0] ST_SW  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SB  = 2'b10;
  localparam logic [1:0] ST_RSV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_MERGE = 3'd2,
    S_WRITE = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  // True when the request must be rejected: misaligned SW/SH or reserved type.
  function automatic logic is_bad_req(input logic [1:0] st_type, input logic [1:0] addr_lo);
    logic bad;
    case (st_type)
      ST_SW:   bad = (addr_lo != 2'b00);
      ST_SH:   bad = addr_lo[0];
      ST_SB:   bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational lane merge: drops a byte or halfword into the addressed lane of a word.
module byte_lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  st_type,
  input  logic [1:0]  byte_sel,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    if (st_type == ST_SB) begin
      case (byte_sel)
        2'd0:    merged[7:0]   = new_data[7:0];
        2'd1:    merged[15:8]  = new_data[7:0];
        2'd2:    merged[23:16] = new_data[7:0];
        default: merged[31:24] = new_data[7:0];
      endcase
    end else if (st_type == ST_SH) begin
      if (byte_sel[1]) merged[31:16] = new_data[15:0];
      else             merged[15:0]  = new_data[15:0];
    end else begin
      merged = new_data;
    end
  end

endmodule

// File: rtl/sub_word_store_ctrl.sv
// Store sequencer for the data memory: SW writes directly, SH/SB read-modify-write.
//
// state   | meaning
// IDLE    | ready for a request; latch it on req_valid
// READ    | mem_re to the latched word address
// MERGE   | mem_rdata valid; capture merged word into wbuf
// WRITE   | mem_we with wbuf, done pulse
// ERR     | err pulse, memory untouched
module sub_word_store_ctrl
  import store_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DM_AW = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_type,
  input  logic [AW-1:0]    req_addr,
  input  logic [31:0]      req_data,
  output logic             done,
  output logic             err,
  output logic [DM_AW-1:0] mem_addr,
  output logic             mem_re,
  input  logic [31:0]      mem_rdata,
  output logic             mem_we,
  output logic [31:0]      mem_wdata
);

  state_t            state, state_nxt;
  logic [1:0]        type_q;
  logic [DM_AW+1:0]  addr_q;
  logic [31:0]       data_q;
  logic [31:0]       wbuf;
  logic [31:0]       merged;
  logic              accept;
  logic              unused_addr_hi;

  assign accept         = (state == S_IDLE) && req_valid;
  assign unused_addr_hi = ^req_addr[AW-1:DM_AW+2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (is_bad_req(req_type, req_addr[1:0])) state_nxt = S_ERR;
          else if (req_type == ST_SW)               state_nxt = S_WRITE;
          else                                      state_nxt = S_READ;
        end
      end
      S_READ:  state_nxt = S_MERGE;
      S_MERGE: state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    mem_re    = (state == S_READ);
    mem_we    = (state == S_WRITE);
    done      = (state == S_WRITE);
    err       = (state == S_ERR);
  end

  // wbuf takes SW data at accept; SH/SB overwrite it with the merged word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      type_q <= ST_SW;
      addr_q <= '0;
      data_q <= '0;
      wbuf   <= '0;
    end else if (accept) begin
      type_q <= req_type;
      addr_q <= req_addr[DM_AW+1:0];
      data_q <= req_data;
      wbuf   <= req_data;
    end else if (state == S_MERGE) begin
      wbuf   <= merged;
    end
  end

  byte_lane_merge u_merge (
    .old_word (mem_rdata),
    .new_data (data_q),
    .st_type  (type_q),
    .byte_sel (addr_q[1:0]),
    .merged   (merged)
  );

  assign mem_addr  = addr_q[DM_AW+1:2];
  assign mem_wdata = wbuf;

endmodule
